// File: rtl/mips_ctrl_pkg.sv
// ============================================================================
//  Module      : mips_ctrl_pkg
//  Description : State encoding and opcode/funct/control-code constants for the
//                multi-cycle MIPS controller, shared with datapath and bench.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      ST_FETCH  = 4'd0,
      ST_DECODE = 4'd1,
      ST_EXEC_R = 4'd2,
      ST_EXEC_I = 4'd3,
      ST_ALUWB  = 4'd4,
      ST_MEMADR = 4'd5,
      ST_MEMRD  = 4'd6,
      ST_MEMWB  = 4'd7,
      ST_MEMWR  = 4'd8,
      ST_BRANCH = 4'd9,
      ST_JUMP   = 4'd10,
      ST_TRAP   = 4'd11
   } state_t;

   localparam logic [5:0] c_op_rtype = 6'b000000;
   localparam logic [5:0] c_op_j     = 6'b000010;
   localparam logic [5:0] c_op_beq   = 6'b000100;
   localparam logic [5:0] c_op_bne   = 6'b000101;
   localparam logic [5:0] c_op_addi  = 6'b001000;
   localparam logic [5:0] c_op_slti  = 6'b001010;
   localparam logic [5:0] c_op_andi  = 6'b001100;
   localparam logic [5:0] c_op_ori   = 6'b001101;
   localparam logic [5:0] c_op_lui   = 6'b001111;
   localparam logic [5:0] c_op_lw    = 6'b100011;
   localparam logic [5:0] c_op_sw    = 6'b101011;

   localparam logic [5:0] c_fn_add   = 6'b100000;
   localparam logic [5:0] c_fn_sub   = 6'b100010;
   localparam logic [5:0] c_fn_and   = 6'b100100;
   localparam logic [5:0] c_fn_or    = 6'b100101;
   localparam logic [5:0] c_fn_slt   = 6'b101010;

   localparam logic [2:0] c_alu_add  = 3'b010;
   localparam logic [2:0] c_alu_sub  = 3'b110;
   localparam logic [2:0] c_alu_and  = 3'b000;
   localparam logic [2:0] c_alu_or   = 3'b001;
   localparam logic [2:0] c_alu_slt  = 3'b111;

   localparam logic [1:0] c_ext_sign  = 2'd0;
   localparam logic [1:0] c_ext_zero  = 2'd1;
   localparam logic [1:0] c_ext_upper = 2'd2;

   localparam logic [1:0] c_srcb_regb   = 2'd0;
   localparam logic [1:0] c_srcb_four   = 2'd1;
   localparam logic [1:0] c_srcb_imm    = 2'd2;
   localparam logic [1:0] c_srcb_imm_sh = 2'd3;

   localparam logic [1:0] c_pcsrc_alu    = 2'd0;
   localparam logic [1:0] c_pcsrc_aluout = 2'd1;
   localparam logic [1:0] c_pcsrc_jump   = 2'd2;

   // Logical immediates are zero-extended; lui places imm in the upper half.
   function automatic logic [1:0] ext_mode_for(input logic [5:0] op);
      logic [1:0] mode;
      mode = c_ext_sign;
      if (op == c_op_andi || op == c_op_ori)
         mode = c_ext_zero;
      else if (op == c_op_lui)
         mode = c_ext_upper;
      return mode;
   endfunction

endpackage

`default_nettype wire

// File: rtl/alu_op_decoder.sv
// ============================================================================
//  Module      : alu_op_decoder
//  Description : Combinational funct/opcode to ALU control decode with valid flag.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_op_decoder
   import mips_ctrl_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output logic [2:0] alu_ctrl,
   output logic       valid
);

   always_comb begin
      alu_ctrl = c_alu_add;
      valid    = 1'b0;
      if (opcode == c_op_rtype) begin
         case (funct)
            c_fn_add: begin alu_ctrl = c_alu_add; valid = 1'b1; end
            c_fn_sub: begin alu_ctrl = c_alu_sub; valid = 1'b1; end
            c_fn_and: begin alu_ctrl = c_alu_and; valid = 1'b1; end
            c_fn_or:  begin alu_ctrl = c_alu_or;  valid = 1'b1; end
            c_fn_slt: begin alu_ctrl = c_alu_slt; valid = 1'b1; end
            default:  ;
         endcase
      end else begin
         // lui uses OR against an unused operand so the extended imm passes through
         case (opcode)
            c_op_addi: begin alu_ctrl = c_alu_add; valid = 1'b1; end
            c_op_slti: begin alu_ctrl = c_alu_slt; valid = 1'b1; end
            c_op_andi: begin alu_ctrl = c_alu_and; valid = 1'b1; end
            c_op_ori:  begin alu_ctrl = c_alu_or;  valid = 1'b1; end
            c_op_lui:  begin alu_ctrl = c_alu_or;  valid = 1'b1; end
            default:   ;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/multicycle_control_fsm.sv
// ============================================================================
//  Module      : multicycle_control_fsm
//  Description : Multi-cycle MIPS sequencing controller over one shared memory
//                port. Optional PERF_CNT_EN adds cycle/instruction counters.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module multicycle_control_fsm
   import mips_ctrl_pkg::*;
#(
   parameter logic [3:0] RESET_STATE = 4'd0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_we,
   output logic       iord,
   output logic       ir_write,
   output logic       pc_en,
   output logic [1:0] pc_src,
   output logic       reg_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] ext_mode,
   output logic [2:0] alu_ctrl,
   output logic       illegal
`ifdef PERF_CNT_EN
   ,
   output logic [31:0] cycle_cnt,
   output logic [31:0] instr_cnt
`endif
);

   state_t     r_state;
   state_t     w_next_state;
   logic       r_illegal;
   logic [2:0] w_dec_alu_ctrl;
   logic       w_dec_valid;

   alu_op_decoder u_alu_op_decoder (
      .opcode   (opcode),
      .funct    (funct),
      .alu_ctrl (w_dec_alu_ctrl),
      .valid    (w_dec_valid)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= state_t'(RESET_STATE);
         r_illegal <= 1'b0;
      end else begin
         r_state <= w_next_state;
         if (w_next_state == ST_TRAP)
            r_illegal <= 1'b1;
      end
   end

   always_comb begin
      w_next_state = r_state;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      iord         = 1'b0;
      ir_write     = 1'b0;
      pc_en        = 1'b0;
      pc_src       = c_pcsrc_alu;
      reg_write    = 1'b0;
      reg_dst      = 1'b0;
      mem_to_reg   = 1'b0;
      alu_src_a    = 1'b0;
      alu_src_b    = c_srcb_regb;
      ext_mode     = c_ext_sign;
      alu_ctrl     = c_alu_add;

      case (r_state)
         ST_FETCH: begin
            mem_req   = 1'b1;
            alu_src_b = c_srcb_four;
            if (mem_ready) begin
               ir_write     = 1'b1;
               pc_en        = 1'b1;
               w_next_state = ST_DECODE;
            end
         end
         ST_DECODE: begin
            alu_src_b = c_srcb_imm_sh;
            case (opcode)
               c_op_rtype:                  w_next_state = ST_EXEC_R;
               c_op_lw, c_op_sw:            w_next_state = ST_MEMADR;
               c_op_beq, c_op_bne:          w_next_state = ST_BRANCH;
               c_op_addi, c_op_slti, c_op_andi,
               c_op_ori, c_op_lui:          w_next_state = ST_EXEC_I;
               c_op_j:                      w_next_state = ST_JUMP;
               default:                     w_next_state = ST_TRAP;
            endcase
         end
         ST_EXEC_R: begin
            alu_src_a    = 1'b1;
            alu_src_b    = c_srcb_regb;
            alu_ctrl     = w_dec_alu_ctrl;
            w_next_state = w_dec_valid ? ST_ALUWB : ST_TRAP;
         end
         ST_EXEC_I: begin
            alu_src_a    = 1'b1;
            alu_src_b    = c_srcb_imm;
            ext_mode     = ext_mode_for(opcode);
            alu_ctrl     = w_dec_alu_ctrl;
            w_next_state = ST_ALUWB;
         end
         ST_ALUWB: begin
            // The IR still holds the instruction, so opcode tells R from I type
            reg_write    = 1'b1;
            reg_dst      = (opcode == c_op_rtype);
            w_next_state = ST_FETCH;
         end
         ST_MEMADR: begin
            alu_src_a    = 1'b1;
            alu_src_b    = c_srcb_imm;
            w_next_state = (opcode == c_op_lw) ? ST_MEMRD : ST_MEMWR;
         end
         ST_MEMRD: begin
            mem_req = 1'b1;
            iord    = 1'b1;
            if (mem_ready)
               w_next_state = ST_MEMWB;
         end
         ST_MEMWB: begin
            reg_write    = 1'b1;
            mem_to_reg   = 1'b1;
            w_next_state = ST_FETCH;
         end
         ST_MEMWR: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            iord    = 1'b1;
            if (mem_ready)
               w_next_state = ST_FETCH;
         end
         ST_BRANCH: begin
            alu_src_a    = 1'b1;
            alu_src_b    = c_srcb_regb;
            alu_ctrl     = c_alu_sub;
            pc_src       = c_pcsrc_aluout;
            pc_en        = (opcode == c_op_beq) ? zero : ~zero;
            w_next_state = ST_FETCH;
         end
         ST_JUMP: begin
            pc_src       = c_pcsrc_jump;
            pc_en        = 1'b1;
            w_next_state = ST_FETCH;
         end
         ST_TRAP: w_next_state = ST_TRAP;
         default: w_next_state = ST_FETCH;
      endcase

      // Reset silences the bus at once, even in the middle of an access
      if (reset) begin
         mem_req    = 1'b0;
         mem_we     = 1'b0;
         iord       = 1'b0;
         ir_write   = 1'b0;
         pc_en      = 1'b0;
         pc_src     = c_pcsrc_alu;
         reg_write  = 1'b0;
         reg_dst    = 1'b0;
         mem_to_reg = 1'b0;
         alu_src_a  = 1'b0;
         alu_src_b  = c_srcb_regb;
         ext_mode   = c_ext_sign;
         alu_ctrl   = c_alu_add;
      end
   end

   assign illegal = r_illegal & ~reset;

`ifdef PERF_CNT_EN
   logic [31:0] r_cycle_cnt;
   logic [31:0] r_instr_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cycle_cnt <= 32'd0;
         r_instr_cnt <= 32'd0;
      end else begin
         r_cycle_cnt <= r_cycle_cnt + 32'd1;
         if (r_state == ST_FETCH && w_next_state == ST_DECODE)
            r_instr_cnt <= r_instr_cnt + 32'd1;
      end
   end

   assign cycle_cnt = r_cycle_cnt;
   assign instr_cnt = r_instr_cnt;
`endif

endmodule

`default_nettype wire
